// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states
// and the iteration-counter sizing helper.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } mdu_state_e;

    // Bits needed to count WIDTH iterations (0..WIDTH-1).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// One combinational iteration of the MDU: shift-add multiply or restoring divide,
// operating on a {upper, lower} double-width accumulator.
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 is_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff;
    logic             fits;

    always_comb begin
        // Multiply: lower half holds the remaining multiplier bits, LSB first.
        mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: upper half is the partial remainder, lower half shifts in quotient bits.
        rem_sh   = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        fits     = (rem_sh >= {1'b0, opnd_i});
        rem_diff = rem_sh[WIDTH-1:0] - opnd_i;
        if (is_div_i) begin
            acc_o = {(fits ? rem_diff : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], fits};
        end else begin
            acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes at issue and the sign is restored in FIN.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned AW = 2 * WIDTH;

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [AW-1:0]    step_acc;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc)
    );

    logic             op_signed;
    logic             op_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [AW-1:0]    prod;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        op_signed = (op == MDU_MULT) || (op == MDU_DIV);
        op_div    = (op == MDU_DIV) || (op == MDU_DIVU);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;

        prod      = neg_res_q ? -acc_q : acc_q;
        quot      = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = neg_rem_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];

        case (state_q)
            IDLE: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start) begin
                    is_div_d  = op_div;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    bzero_d   = (b == '0);
                    // Multiplier rides in the accumulator; multiplicand is the addend.
                    opnd_d    = op_div ? b_mag : a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
            end
            FIN: begin
                if (is_div_q) begin
                    lo_d = bzero_q ? {WIDTH{1'b1}} : quot;
                    hi_d = rem;
                end else begin
                    hi_d = prod[AW-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo: arithmetic vectors, latency,
// concurrency with MTHI/MTLO and reset abort.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Issue one op, scramble operands after the start edge, wait (bounded) for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_multu_max();
        int lat, bc;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d expected 33", lat); end
        checks++;
        if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d expected 33", bc); end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++; $display("FAIL multu_max hi=%h lo=%h expected fffffffe 00000001", hi, lo);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_one_pulse got %b expected 0", done); end
    endtask

    task automatic test_mult_signed();
        int lat, bc;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bc);
        checks++;
        if (lat !== 33 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL mult_neg3x7 lat=%0d hi=%h lo=%h expected 33 ffffffff ffffffeb", lat, hi, lo);
        end
        run_op(2'b00, 32'hFFFF_FFFA, 32'hFFFF_FFF9, lat, bc);
        checks++;
        if (hi !== 32'h0 || lo !== 32'd42) begin
            errors++; $display("FAIL mult_neg6xneg7 hi=%h lo=%h expected 0 2a", hi, lo);
        end
    endtask

    task automatic test_divide();
        int lat, bc;
        run_op(2'b11, 32'd100, 32'd7, lat, bc);
        checks++;
        if (lat !== 33 || lo !== 32'd14 || hi !== 32'd2) begin
            errors++; $display("FAIL divu_100_7 lat=%0d hi=%h lo=%h expected 33 2 e", lat, hi, lo);
        end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bc);
        checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_neg7_2 hi=%h lo=%h expected ffffffff fffffffd", hi, lo);
        end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        checks++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
            errors++; $display("FAIL div_overflow hi=%h lo=%h expected 0 80000000", hi, lo);
        end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bc);
        checks++;
        if (lo !== 32'h7FFF_FFFC || hi !== 32'd1) begin
            errors++; $display("FAIL divu_big hi=%h lo=%h expected 1 7ffffffc", hi, lo);
        end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        run_op(2'b11, 32'h0000_1234, 32'd0, lat, bc);
        checks++;
        if (lat !== 33 || lo !== 32'hFFFF_FFFF || hi !== 32'h0000_1234) begin
            errors++; $display("FAIL divu_by_zero lat=%0d hi=%h lo=%h expected 33 1234 ffffffff", lat, hi, lo);
        end
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, lat, bc);
        checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFB) begin
            errors++; $display("FAIL div_by_zero hi=%h lo=%h expected fffffffb ffffffff", hi, lo);
        end
    endtask

    task automatic test_concurrency();
        int done_cnt;
        int done_at;
        int lat;
        done_cnt = 0; done_at = -1;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            start = (k == 5);
            if (k == 5) begin op = 2'b01; a = 32'd7; b = 32'd7; end
            wr_hi = (k == 10);
            wdata = (k == 10) ? 32'hAA : 32'h0;
            @(posedge clk); #1;
            start = 1'b0; wr_hi = 1'b0;
            if (done) begin done_cnt++; done_at = k; end
        end
        checks++;
        if (done_cnt !== 1 || done_at !== 33) begin
            errors++; $display("FAIL conc_single_done count=%0d at=%0d expected 1 at 33", done_cnt, done_at);
        end
        checks++;
        if (lo !== 32'd30 || hi !== 32'd0) begin
            errors++; $display("FAIL conc_result hi=%h lo=%h expected 0 1e", hi, lo);
        end
        // Done cycle: MTLO plus a new MULTU 3*4 in the same idle cycle.
        @(negedge clk);
        wr_lo = 1'b1; wdata = 32'h55; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        wr_lo = 1'b0; start = 1'b0; a = 32'd9; b = 32'd9;
        checks++;
        if (lo !== 32'h55 || busy !== 1'b1) begin
            errors++; $display("FAIL mtlo_and_start lo=%h busy=%b expected 55 1", lo, busy);
        end
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 33 || lo !== 32'd12 || hi !== 32'd0) begin
            errors++; $display("FAIL start_on_done lat=%0d hi=%h lo=%h expected 33 0 c", lat, hi, lo);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc;
        int stray;
        stray = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL reset_abort busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
        end
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL reset_no_done stray=%0d expected 0", stray); end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bc);
        checks++;
        if (lat !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL post_reset_div lat=%0d hi=%h lo=%h expected 33 ffffffff fffffffd", lat, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_divide();
        test_div_zero();
        test_concurrency();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
